// File: rtl/qbert_pkg.sv
// Shared definitions for the Q*bert ROM load path: ioctl indices, FSM states
// and default region sizes.
package qbert_pkg;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  localparam int DEF_MAIN_SIZE = 65536;
  localparam int DEF_SND_SIZE  = 4096;
  localparam int DEF_RST_HOLD  = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_MAIN,
    ISSUE_SND
  } load_state_e;

endpackage

// File: rtl/reset_stretch.sv
// Detects start/end of a ROM download and keeps the game core in reset during
// the download and for RST_HOLD cycles afterwards.
module reset_stretch
  import qbert_pkg::*;
#(
  parameter int RST_HOLD = DEF_RST_HOLD
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ioctl_download,
  input  logic rom_sel,
  output logic dl_start,
  output logic core_reset
);

  localparam logic [9:0] HOLD_LOAD = 10'(RST_HOLD - 1);

  logic       dl_prev;
  logic       dl_fall;
  logic [9:0] hold;

  assign dl_start = ioctl_download & ~dl_prev & rom_sel;
  assign dl_fall  = ~ioctl_download & dl_prev & rom_sel;

  // The falling-edge term covers the one cycle before hold is loaded, so
  // core_reset never glitches low at the end of a download.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_prev <= 1'b0;
      hold    <= '0;
    end else begin
      dl_prev <= ioctl_download;
      if (dl_fall)
        hold <= HOLD_LOAD;
      else if (dl_start)
        hold <= '0;
      else if (hold != '0)
        hold <= hold - 10'd1;
    end
  end

  assign core_reset = reset | (ioctl_download & rom_sel) | dl_fall | (hold != '0);

endmodule

// File: rtl/rom_load_ctrl.sv
// Routes the hps_io download stream to the main/sound ROM init ports, the DIP
// bank and the module byte, with ioctl_wait back-pressure per ROM byte.
module rom_load_ctrl
  import qbert_pkg::*;
#(
  parameter int MAIN_SIZE = DEF_MAIN_SIZE,
  parameter int SND_SIZE  = DEF_SND_SIZE,
  parameter int RST_HOLD  = DEF_RST_HOLD
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        main_wr,
  output logic [15:0] main_addr,
  output logic [7:0]  main_data,
  input  logic        main_rdy,
  output logic        snd_wr,
  output logic [11:0] snd_addr,
  output logic [7:0]  snd_data,
  input  logic        snd_rdy,
  output logic [63:0] dip_sw,
  output logic [7:0]  mod,
  output logic        core_reset,
  output logic        load_err,
  output logic [24:0] bytes_loaded
);

  localparam logic [24:0] MAIN_LIM = 25'(MAIN_SIZE);
  localparam logic [24:0] SND_LIM  = 25'(MAIN_SIZE + SND_SIZE);

  load_state_e state, state_next;

  logic        rom_sel, rom_wr, in_main, in_snd, accept, dl_start;
  logic [15:0] main_addr_q;
  logic [7:0]  main_data_q, snd_data_q;
  logic [11:0] snd_addr_q;
  logic [63:0] dip_q = '0;
  logic [7:0]  mod_q = 8'hFF;

  assign rom_sel = (ioctl_index == IDX_ROM);
  assign rom_wr  = ioctl_wr & rom_sel;
  assign in_main = (ioctl_addr < MAIN_LIM);
  assign in_snd  = !in_main && (ioctl_addr < SND_LIM);
  assign accept  = ((state == ISSUE_MAIN) && main_rdy) || ((state == ISSUE_SND) && snd_rdy);

  always_ff @(posedge clk_sys) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rom_wr && in_main)
          state_next = ISSUE_MAIN;
        else if (rom_wr && in_snd)
          state_next = ISSUE_SND;
      end
      ISSUE_MAIN: if (main_rdy) state_next = IDLE;
      ISSUE_SND:  if (snd_rdy)  state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    main_wr    = (state == ISSUE_MAIN);
    snd_wr     = (state == ISSUE_SND);
    ioctl_wait = (state != IDLE);
  end

  // Payload and configuration registers carry no reset: dip_sw and mod must
  // survive a core reset, and the ROM payload is only meaningful while issuing.
  always_ff @(posedge clk_sys) begin
    if (state == IDLE && rom_wr && in_main) begin
      main_addr_q <= ioctl_addr[15:0];
      main_data_q <= ioctl_dout;
    end
    if (state == IDLE && rom_wr && in_snd) begin
      snd_addr_q <= 12'(ioctl_addr - MAIN_LIM);
      snd_data_q <= ioctl_dout;
    end
    if (state == IDLE && ioctl_wr && ioctl_index == IDX_MOD && ioctl_addr == '0)
      mod_q <= ioctl_dout;
    if (state == IDLE && ioctl_wr && ioctl_index == IDX_DIP && ioctl_addr < 25'd8)
      dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      load_err     <= 1'b0;
      bytes_loaded <= '0;
    end else begin
      if (dl_start) begin
        load_err     <= 1'b0;
        bytes_loaded <= '0;
      end else if (accept && bytes_loaded != '1) begin
        bytes_loaded <= bytes_loaded + 25'd1;
      end
      if ((ioctl_wr && state != IDLE) || (state == IDLE && rom_wr && !in_main && !in_snd))
        load_err <= 1'b1;
    end
  end

  assign main_addr = main_addr_q;
  assign main_data = main_data_q;
  assign snd_addr  = snd_addr_q;
  assign snd_data  = snd_data_q;
  assign dip_sw    = dip_q;
  assign mod       = mod_q;

  reset_stretch #(
    .RST_HOLD(RST_HOLD)
  ) u_reset_stretch (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .rom_sel       (rom_sel),
    .dl_start      (dl_start),
    .core_reset    (core_reset)
  );

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench for rom_load_ctrl: expected writes are queued as stimulus is
// issued and a negedge monitor checks every main/sound strobe against them.
module tb_rom_load_ctrl;

  localparam int MAIN_SIZE = 65536;
  localparam int SND_SIZE  = 4096;
  localparam int RST_HOLD  = 1024;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        main_wr;
  logic [15:0] main_addr;
  logic [7:0]  main_data;
  logic        main_rdy;
  logic        snd_wr;
  logic [11:0] snd_addr;
  logic [7:0]  snd_data;
  logic        snd_rdy;
  logic [63:0] dip_sw;
  logic [7:0]  mod;
  logic        core_reset;
  logic        load_err;
  logic [24:0] bytes_loaded;

  typedef struct {
    logic        isSnd;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cycles;
  } expTxn_t;

  expTxn_t expQ[$];
  int checks = 0;
  int errors = 0;

  rom_load_ctrl #(
    .MAIN_SIZE(MAIN_SIZE),
    .SND_SIZE (SND_SIZE),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .main_wr       (main_wr),
    .main_addr     (main_addr),
    .main_data     (main_data),
    .main_rdy      (main_rdy),
    .snd_wr        (snd_wr),
    .snd_addr      (snd_addr),
    .snd_data      (snd_data),
    .snd_rdy       (snd_rdy),
    .dip_sw        (dip_sw),
    .mod           (mod),
    .core_reset    (core_reset),
    .load_err      (load_err),
    .bytes_loaded  (bytes_loaded)
  );

  always #10 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr    = 1'b0;
  endtask

  task automatic pushExp(input logic isSnd, input logic [15:0] addr, input logic [7:0] data, input int cycles);
    expTxn_t e;
    e.isSnd  = isSnd;
    e.addr   = addr;
    e.data   = data;
    e.cycles = cycles;
    expQ.push_back(e);
  endtask

  // Monitor: payload checked against the queue head on every strobe cycle,
  // strobe length checked and the entry retired when the strobe drops.
  int  mainCnt = 0;
  bit  mainAct = 0;
  int  sndCnt  = 0;
  bit  sndAct  = 0;

  always @(negedge clk_sys) begin
    if (main_wr === 1'b1) begin
      mainCnt = mainAct ? mainCnt + 1 : 1;
      mainAct = 1;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected main_wr: got addr %0h data %0h expected no strobe", main_addr, main_data);
      end else begin
        checkOutput("main target", 64'(1'b0), 64'(expQ[0].isSnd));
        checkOutput("main addr", 64'(main_addr), 64'(expQ[0].addr));
        checkOutput("main data", 64'(main_data), 64'(expQ[0].data));
      end
    end else if (mainAct) begin
      mainAct = 0;
      if (expQ.size() != 0) begin
        checkOutput("main strobe cycles", 64'(mainCnt), 64'(expQ[0].cycles));
        void'(expQ.pop_front());
      end
    end
  end

  always @(negedge clk_sys) begin
    if (snd_wr === 1'b1) begin
      sndCnt = sndAct ? sndCnt + 1 : 1;
      sndAct = 1;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected snd_wr: got addr %0h data %0h expected no strobe", snd_addr, snd_data);
      end else begin
        checkOutput("snd target", 64'(1'b1), 64'(expQ[0].isSnd));
        checkOutput("snd addr", 64'(snd_addr), 64'(expQ[0].addr[11:0]));
        checkOutput("snd data", 64'(snd_data), 64'(expQ[0].data));
      end
    end else if (sndAct) begin
      sndAct = 0;
      if (expQ.size() != 0) begin
        checkOutput("snd strobe cycles", 64'(sndCnt), 64'(expQ[0].cycles));
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    main_rdy       = 1'b1;
    snd_rdy        = 1'b1;
    repeat (3) tick();

    checkOutput("reset main_wr", 64'(main_wr), 64'd0);
    checkOutput("reset snd_wr", 64'(snd_wr), 64'd0);
    checkOutput("reset ioctl_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("reset load_err", 64'(load_err), 64'd0);
    checkOutput("reset bytes_loaded", 64'(bytes_loaded), 64'd0);
    checkOutput("powerup dip_sw", dip_sw, 64'd0);
    checkOutput("powerup mod", 64'(mod), 64'hFF);
    checkOutput("reset core_reset", 64'(core_reset), 64'd1);

    reset = 1'b0;
    tick();
    checkOutput("idle core_reset", 64'(core_reset), 64'd0);

    $display("[TB] ROM download: main write, stalled sound write, boundaries");
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    checkOutput("download core_reset", 64'(core_reset), 64'd1);

    pushExp(1'b0, 16'h0010, 8'hA5, 1);
    applyStimulus(8'd0, 25'h0010, 8'hA5);
    checkOutput("main ioctl_wait t+1", 64'(ioctl_wait), 64'd1);
    tick();
    checkOutput("main ioctl_wait t+2", 64'(ioctl_wait), 64'd0);
    checkOutput("main bytes_loaded", 64'(bytes_loaded), 64'd1);

    snd_rdy = 1'b0;
    pushExp(1'b1, 16'h0003, 8'h3C, 6);
    applyStimulus(8'd0, 25'(MAIN_SIZE + 3), 8'h3C);
    repeat (5) tick();
    checkOutput("snd stall ioctl_wait", 64'(ioctl_wait), 64'd1);
    checkOutput("snd stall bytes_loaded", 64'(bytes_loaded), 64'd1);
    snd_rdy = 1'b1;
    tick();
    checkOutput("snd done ioctl_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("snd bytes_loaded", 64'(bytes_loaded), 64'd2);

    pushExp(1'b1, 16'h0000, 8'hC3, 1);
    applyStimulus(8'd0, 25'(MAIN_SIZE), 8'hC3);
    tick();
    checkOutput("snd first addr bytes_loaded", 64'(bytes_loaded), 64'd3);

    applyStimulus(8'd0, 25'(MAIN_SIZE + SND_SIZE), 8'h77);
    checkOutput("oor ioctl_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("oor load_err", 64'(load_err), 64'd1);
    tick();
    checkOutput("oor bytes_loaded", 64'(bytes_loaded), 64'd3);

    $display("[TB] reset stretch after download end");
    ioctl_download = 1'b0;
    checkOutput("hold at T", 64'(core_reset), 64'd1);
    repeat (RST_HOLD - 1) tick();
    checkOutput("hold at T+RST_HOLD-1", 64'(core_reset), 64'd1);
    repeat (2) tick();
    checkOutput("hold at T+RST_HOLD+1", 64'(core_reset), 64'd0);
    checkOutput("load_err kept", 64'(load_err), 64'd1);

    ioctl_download = 1'b1;
    tick();
    checkOutput("restart clears load_err", 64'(load_err), 64'd0);
    checkOutput("restart clears bytes_loaded", 64'(bytes_loaded), 64'd0);
    ioctl_download = 1'b0;
    repeat (500) tick();
    checkOutput("hold mid window", 64'(core_reset), 64'd1);
    ioctl_download = 1'b1;
    tick();
    ioctl_download = 1'b0;
    repeat (RST_HOLD - 1) tick();
    checkOutput("rehold at T+RST_HOLD-1", 64'(core_reset), 64'd1);
    repeat (2) tick();
    checkOutput("rehold at T+RST_HOLD+1", 64'(core_reset), 64'd0);

    $display("[TB] DIP bank and module byte");
    ioctl_index    = 8'd254;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 8; i++)
      applyStimulus(8'd254, 25'(i), 8'((i + 1) * 8'h11));
    applyStimulus(8'd254, 25'd8, 8'hEE);
    ioctl_download = 1'b0;
    tick();
    checkOutput("dip_sw", dip_sw, 64'h8877665544332211);
    checkOutput("dip core_reset", 64'(core_reset), 64'd0);
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    tick();
    applyStimulus(8'd1, 25'd0, 8'h01);
    applyStimulus(8'd1, 25'd1, 8'h55);
    ioctl_download = 1'b0;
    tick();
    checkOutput("mod", 64'(mod), 64'h01);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkOutput("dip_sw after reset", dip_sw, 64'h8877665544332211);
    checkOutput("mod after reset", 64'(mod), 64'h01);

    $display("[TB] reset while issuing a sound write");
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    pushExp(1'b0, 16'hFFFF, 8'h5A, 1);
    applyStimulus(8'd0, 25'(MAIN_SIZE - 1), 8'h5A);
    tick();
    checkOutput("last main bytes_loaded", 64'(bytes_loaded), 64'd1);
    snd_rdy = 1'b0;
    pushExp(1'b1, 16'h0005, 8'h42, 2);
    applyStimulus(8'd0, 25'(MAIN_SIZE + 5), 8'h42);
    tick();
    checkOutput("issue ioctl_wait", 64'(ioctl_wait), 64'd1);
    reset = 1'b1;
    tick();
    checkOutput("midreset snd_wr", 64'(snd_wr), 64'd0);
    checkOutput("midreset ioctl_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("midreset bytes_loaded", 64'(bytes_loaded), 64'd0);
    reset          = 1'b0;
    snd_rdy        = 1'b1;
    ioctl_download = 1'b0;
    repeat (3) tick();
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences the HPS ioctl download stream into the board's loadable resources: main-board ROM/RAM init port, sound-board ROM init port, DIP-switch bank and game-module byte.
- Sits between hps_io and mylstar_board / ma216_board in the top level.
- Replaces ad-hoc address decoding with one arbitrated write path per target, using ioctl_wait back-pressure and a ready handshake.
- Holds the game core in reset during a ROM load and for a programmable time after it.

Parameters:
- MAIN_SIZE, 65536: bytes routed to the main-board init port (file offsets 0..MAIN_SIZE-1).
- SND_SIZE, 4096: bytes routed to the sound-board init port, following the main region.
- RST_HOLD, 1024: clk_sys cycles core_reset stays high after a ROM download ends; 10-bit counter.

Ports:
- clk_sys  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  download in progress
- ioctl_index  in  8  0=ROM, 1=module byte, 254=DIP bank
- ioctl_wr  in  1  byte strobe, one cycle
- ioctl_addr  in  25  file offset
- ioctl_dout  in  8  byte
- ioctl_wait  out  1  back-pressure to hps_io
- main_wr  out  1  main-board write request
- main_addr  out  16  main-board address
- main_data  out  8  main-board data
- main_rdy  in  1  main-board accepts in the current cycle
- snd_wr  out  1  sound-board write request
- snd_addr  out  12  sound-board address
- snd_data  out  8  sound-board data
- snd_rdy  in  1  sound-board accepts in the current cycle
- dip_sw  out  64  DIP bytes 0..7, byte n at [8n+7:8n]
- mod  out  8  game-module byte
- core_reset  out  1  reset to game boards
- load_err  out  1  sticky: ROM byte beyond MAIN_SIZE+SND_SIZE
- bytes_loaded  out  25  count of ROM bytes accepted by a target

Behaviour:
- Clocking and reset: single clock clk_sys; reset synchronous active-high.
- On reset:
  - FSM goes to IDLE; main_wr=snd_wr=0; ioctl_wait=0.
  - load_err=0, bytes_loaded=0, hold counter=0.
  - Any pending write is discarded.
  - dip_sw and mod are NOT cleared by reset; power-up values are dip_sw=0 and mod=8'hFF.
- FSM states:
  - IDLE: ioctl_wait=0. On ioctl_wr with index 0:
    - addr<MAIN_SIZE: latch main_addr=addr[15:0] and main_data; go to ISSUE_MAIN.
    - MAIN_SIZE<=addr<MAIN_SIZE+SND_SIZE: latch snd_addr=addr-MAIN_SIZE; go to ISSUE_SND.
    - Otherwise: set load_err, stay in IDLE, drop the byte.
  - Index 1 with addr==0: mod<=dout in the same cycle; other addresses ignored. No state change.
  - Index 254 with addr<8: dip byte[addr[2:0]]<=dout. No state change.
  - Any other index: ignored.
  - ISSUE_MAIN / ISSUE_SND: the matching wr output is 1; addr/data are stable.
    - ioctl_wait = 1, combinational on state!=IDLE.
    - In the cycle the matching rdy=1: wr drops next cycle, bytes_loaded+1, return to IDLE.
    - No timeout.
- Latency:
  - ioctl_wr at cycle t drives the wr output at t+1.
  - With rdy=1 at t+1, the FSM is back in IDLE at t+2.
  - Best case is one stall cycle per ROM byte.
- ioctl_wr arriving in a non-IDLE state is a protocol violation: the byte is dropped and load_err is set.
- Download start: a rising edge of ioctl_download with index 0 clears load_err and bytes_loaded.
- core_reset = reset | (ioctl_download & index==0) | (hold!=0).
  - The falling edge of ioctl_download while index==0 loads hold=RST_HOLD-1.
  - hold decrements to 0 and saturates there.
  - A new download during hold restarts the sequence.
- Wrap-around: bytes_loaded saturates at all-ones. The snd address subtraction is done at 25 bits and truncated to 12.
- Reset mid-transfer: the wr output drops in the next cycle and the byte is lost; hps_io is unblocked because ioctl_wait=0.

Decomposition:
- Shared package qbert_pkg:
  - ioctl index constants IDX_ROM=0, IDX_MOD=1, IDX_DIP=254;
  - FSM state enum (IDLE, ISSUE_MAIN, ISSUE_SND);
  - default MAIN_SIZE, SND_SIZE, RST_HOLD.
- One natural sub-module, reset_stretch: edge detect plus hold counter generating core_reset.

Test Plan:
- Main write: index 0, addr 0x0010, data 0xA5, main_rdy tied 1 -> main_wr high exactly 1 cycle at t+1 with addr 0x0010, data 0xA5; ioctl_wait high 1 cycle; bytes_loaded=1.
- Sound write with stall: addr MAIN_SIZE+3, data 0x3C, snd_rdy low 5 cycles -> snd_wr and ioctl_wait held 6 cycles, snd_addr=0x003, data stable throughout; main_wr never asserted.
- Out of range: addr MAIN_SIZE+SND_SIZE -> no wr strobe; load_err=1; a new index-0 download start clears it.
- DIP and module: index 254 bytes 0x11..0x88 at addr 0..7 -> dip_sw=64'h8877665544332211; index 1 addr 0 data 0x01 -> mod=0x01; asserting reset afterwards leaves both unchanged.
- Reset stretch: ROM download ends at cycle T -> core_reset stays high through T+RST_HOLD-1 and is low at T+RST_HOLD+1; a second download inside the window restarts the hold.
- Reset mid-issue: assert reset while in ISSUE_SND with snd_rdy=0 -> snd_wr=0 and ioctl_wait=0 next cycle, bytes_loaded=0.
